// File: rtl/scoreboard_pkg.sv
// Shared scoreboard definitions: game states, tennis score codes, the saturation
// limit and the per-point scoring steps for both modes.
package scoreboard_pkg;

    localparam int SCORE_W = 8;

    typedef enum logic [0:0] {
        ST_PLAY = 1'b0,
        ST_WON  = 1'b1
    } game_state_e;

    localparam logic [SCORE_W-1:0] TEN_0     = 8'd0;
    localparam logic [SCORE_W-1:0] TEN_15    = 8'd1;
    localparam logic [SCORE_W-1:0] TEN_30    = 8'd2;
    localparam logic [SCORE_W-1:0] TEN_40    = 8'd3;
    localparam logic [SCORE_W-1:0] TEN_ADV   = 8'd4;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 8'd99;

    typedef struct packed {
        logic [SCORE_W-1:0] scorer;
        logic [SCORE_W-1:0] opp;
        logic               win;
    } point_res_t;

    function automatic point_res_t std_step(input logic [SCORE_W-1:0] s,
                                            input logic [SCORE_W-1:0] o,
                                            input logic [SCORE_W-1:0] win_pts);
        point_res_t       r;
        logic [SCORE_W:0] nxt;
        r.scorer = s;
        r.opp    = o;
        r.win    = 1'b0;
        nxt      = {1'b0, s} + 9'd1;
        if (s >= SCORE_MAX) begin
            r.scorer = s;
        end else begin
            r.scorer = nxt[SCORE_W-1:0];
            // 9-bit compare so a lead of two can't wrap near the top of the range
            r.win    = (nxt >= {1'b0, win_pts}) && (nxt >= ({1'b0, o} + 9'd2));
        end
        return r;
    endfunction

    function automatic point_res_t tennis_step(input logic [SCORE_W-1:0] s,
                                               input logic [SCORE_W-1:0] o);
        point_res_t r;
        r.scorer = s;
        r.opp    = o;
        r.win    = 1'b0;
        if (s < TEN_40) begin
            r.scorer = s + 8'd1;
        end else if (o == TEN_ADV) begin
            r.scorer = TEN_40;
            r.opp    = TEN_40;
        end else if ((s == TEN_40) && (o == TEN_40)) begin
            r.scorer = TEN_ADV;
        end else begin
            r.win = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw button conditioning: 2-flop synchronizer, stable-count debouncer and a
// rising-edge press pulse that stays disarmed until the button is seen released.
module button_debouncer #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_r;
    logic [1:0]       vld_r;
    logic             deb_r;
    logic             deb_q_r;
    logic             armed_r;
    logic [CNT_W-1:0] cnt_r;

    // synchronizer, debounce counter, edge history and release arming
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_r  <= 2'b00;
            vld_r   <= 2'b00;
            deb_r   <= 1'b0;
            deb_q_r <= 1'b0;
            armed_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            sync_r  <= {sync_r[0], btn_i};
            vld_r   <= {vld_r[0], 1'b1};
            deb_q_r <= deb_r;
            if (sync_r[1] != deb_r) begin
                if (cnt_r == CNT_LAST) begin
                    deb_r <= sync_r[1];
                    cnt_r <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
            // vld_r skips the reset-cleared synchronizer contents before arming
            if (vld_r[1] && !sync_r[1] && !deb_r) begin
                armed_r <= 1'b1;
            end
        end
    end

    assign press_o = deb_r & ~deb_q_r & armed_r;

endmodule

// File: rtl/score_keeper.sv
// Two-player score keeper with standard (first to WIN_POINTS, win by two) and
// tennis-game scoring, debounced buttons and a PLAY/WON game FSM.
module score_keeper
    import scoreboard_pkg::*;
#(
    parameter int DEB_CYCLES = 1000000,
    parameter int WIN_POINTS = 11
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               p1_btn_i,
    input  logic               p2_btn_i,
    input  logic               new_game_btn_i,
    input  logic               mode_tennis_i,
    output logic [SCORE_W-1:0] p1_score_o,
    output logic [SCORE_W-1:0] p2_score_o,
    output logic               p1_win_o,
    output logic               p2_win_o,
    output logic               point_o
);

    localparam logic [SCORE_W-1:0] WIN_PTS = SCORE_W'(WIN_POINTS);

    logic               p1_press_s, p2_press_s, ng_press_s;
    logic               mode_r, clear_s;
    game_state_e        state_r, state_nxt_s;
    logic [SCORE_W-1:0] p1_score_r, p2_score_r, p1_nxt_s, p2_nxt_s;
    logic               p1_win_r, p2_win_r, w1_nxt_s, w2_nxt_s;
    logic               point_r, point_nxt_s;
    point_res_t         p1_res_s, p2_res_s;

    button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_p1 (
        .clk_i(clk_i), .rst_i(rst_i), .btn_i(p1_btn_i), .press_o(p1_press_s));
    button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_p2 (
        .clk_i(clk_i), .rst_i(rst_i), .btn_i(p2_btn_i), .press_o(p2_press_s));
    button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ng (
        .clk_i(clk_i), .rst_i(rst_i), .btn_i(new_game_btn_i), .press_o(ng_press_s));

    // a flipped mode switch restarts the game exactly like a new-game press
    assign clear_s = ng_press_s | (mode_tennis_i ^ mode_r);

    // state, mode and registered score outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_PLAY;
            mode_r     <= mode_tennis_i;
            p1_score_r <= 8'd0;
            p2_score_r <= 8'd0;
            p1_win_r   <= 1'b0;
            p2_win_r   <= 1'b0;
            point_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            mode_r     <= mode_tennis_i;
            p1_score_r <= p1_nxt_s;
            p2_score_r <= p2_nxt_s;
            p1_win_r   <= w1_nxt_s;
            p2_win_r   <= w2_nxt_s;
            point_r    <= point_nxt_s;
        end
    end

    // next-state and scoring decision
    always_comb begin
        p1_res_s    = mode_r ? tennis_step(p1_score_r, p2_score_r)
                             : std_step(p1_score_r, p2_score_r, WIN_PTS);
        p2_res_s    = mode_r ? tennis_step(p2_score_r, p1_score_r)
                             : std_step(p2_score_r, p1_score_r, WIN_PTS);
        state_nxt_s = state_r;
        p1_nxt_s    = p1_score_r;
        p2_nxt_s    = p2_score_r;
        w1_nxt_s    = p1_win_r;
        w2_nxt_s    = p2_win_r;
        point_nxt_s = 1'b0;
        if (clear_s) begin
            state_nxt_s = ST_PLAY;
            p1_nxt_s    = 8'd0;
            p2_nxt_s    = 8'd0;
            w1_nxt_s    = 1'b0;
            w2_nxt_s    = 1'b0;
        end else begin
            case (state_r)
                ST_PLAY: begin
                    // simultaneous point presses cancel each other
                    if (p1_press_s && !p2_press_s) begin
                        p1_nxt_s = p1_res_s.scorer;
                        p2_nxt_s = p1_res_s.opp;
                        w1_nxt_s = p1_res_s.win;
                    end else if (p2_press_s && !p1_press_s) begin
                        p2_nxt_s = p2_res_s.scorer;
                        p1_nxt_s = p2_res_s.opp;
                        w2_nxt_s = p2_res_s.win;
                    end else begin
                        p1_nxt_s = p1_score_r;
                    end
                    point_nxt_s = (p1_nxt_s != p1_score_r) || (p2_nxt_s != p2_score_r) ||
                                  (w1_nxt_s != p1_win_r) || (w2_nxt_s != p2_win_r);
                    if (w1_nxt_s || w2_nxt_s) begin
                        state_nxt_s = ST_WON;
                    end else begin
                        state_nxt_s = ST_PLAY;
                    end
                end
                ST_WON: begin
                    state_nxt_s = ST_WON;
                end
                default: begin
                    state_nxt_s = ST_PLAY;
                end
            endcase
        end
    end

    assign p1_score_o = p1_score_r;
    assign p2_score_o = p2_score_r;
    assign p1_win_o   = p1_win_r;
    assign p2_win_o   = p2_win_r;
    assign point_o    = point_r;

endmodule

// File: tb/tb_score_keeper.sv
// Directed table-driven bench for score_keeper with a short debounce window.
module tb_score_keeper;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       p1_btn_i = 1'b0, p2_btn_i = 1'b0, new_game_btn_i = 1'b0;
    logic       mode_tennis_i = 1'b0;
    logic [7:0] p1_score_o, p2_score_o;
    logic       p1_win_o, p2_win_o, point_o;

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;

    score_keeper #(.DEB_CYCLES(4), .WIN_POINTS(11)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p1_btn_i(p1_btn_i), .p2_btn_i(p2_btn_i), .new_game_btn_i(new_game_btn_i),
        .mode_tennis_i(mode_tennis_i),
        .p1_score_o(p1_score_o), .p2_score_o(p2_score_o),
        .p1_win_o(p1_win_o), .p2_win_o(p2_win_o), .point_o(point_o));

    always #5 clk_i = ~clk_i;

    // count point pulses, sampled away from the active edge
    always @(negedge clk_i) begin
        if (point_o === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    typedef struct {
        logic       mode;
        int         fill;
        logic       b1, b2, bn;
        logic [7:0] e1, e2;
        logic       ew1, ew2;
        int         epul;
    } vec_t;

    vec_t vecs[40];
    int   nv = 0;

    task automatic add(input logic mode, input int fill, input logic b1, input logic b2,
                       input logic bn, input int e1, input int e2, input logic ew1,
                       input logic ew2, input int epul);
        vecs[nv] = '{mode, fill, b1, b2, bn, 8'(e1), 8'(e2), ew1, ew2, epul};
        nv++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int e1, input int e2, input int ew1,
                             input int ew2, input int epul, input int base);
        chk({tag, " p1_score"}, int'(p1_score_o), e1);
        chk({tag, " p2_score"}, int'(p2_score_o), e2);
        chk({tag, " p1_win"}, int'(p1_win_o), ew1);
        chk({tag, " p2_win"}, int'(p2_win_o), ew2);
        chk({tag, " pulses"}, pulse_cnt - base, epul);
    endtask

    // hold the chosen buttons long enough to debounce, then release fully
    task automatic press(input logic b1, input logic b2, input logic bn);
        p1_btn_i = b1; p2_btn_i = b2; new_game_btn_i = bn;
        repeat (6) @(negedge clk_i);
        p1_btn_i = 1'b0; p2_btn_i = 1'b0; new_game_btn_i = 1'b0;
        repeat (7) @(negedge clk_i);
    endtask

    initial begin
        int base;
        // reset state
        repeat (2) @(negedge clk_i);
        check_all("reset", 0, 0, 0, 0, 0, pulse_cnt);
        chk("reset point_o", int'(point_o), 0);
        rst_i = 1'b0;
        repeat (5) @(negedge clk_i);

        // 3-cycle glitch must not count
        base = pulse_cnt;
        p1_btn_i = 1'b1;
        repeat (3) @(negedge clk_i);
        p1_btn_i = 1'b0;
        repeat (12) @(negedge clk_i);
        check_all("glitch", 0, 0, 0, 0, 0, base);

        // long hold gives exactly one point
        base = pulse_cnt;
        p1_btn_i = 1'b1;
        repeat (20) @(negedge clk_i);
        p1_btn_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check_all("hold", 1, 0, 0, 0, 1, base);

        // mode fill b1 b2 bn  e1  e2 w1 w2 pulses
        add(0, 0, 0, 0, 1,   0,  0, 0, 0, 0);
        add(0, 0, 1, 0, 0,   1,  0, 0, 0, 1);
        add(0, 0, 0, 1, 0,   1,  1, 0, 0, 1);
        add(0, 0, 1, 1, 0,   1,  1, 0, 0, 0);
        add(0, 0, 1, 0, 1,   0,  0, 0, 0, 0);
        add(0, 10, 1, 0, 0, 11, 10, 0, 0, 1);
        add(0, 0, 1, 0, 0,  12, 10, 1, 0, 1);
        add(0, 0, 0, 1, 0,  12, 10, 1, 0, 0);
        add(0, 0, 0, 0, 1,   0,  0, 0, 0, 0);
        add(0, 98, 1, 0, 0, 99, 98, 0, 0, 1);
        add(0, 0, 1, 0, 0,  99, 98, 0, 0, 0);
        add(0, 0, 0, 1, 0,  99, 99, 0, 0, 1);
        add(0, 0, 0, 1, 0,  99, 99, 0, 0, 0);
        add(1, 0, 0, 0, 0,   0,  0, 0, 0, 0);
        add(1, 0, 1, 0, 0,   1,  0, 0, 0, 1);
        add(1, 0, 1, 0, 0,   2,  0, 0, 0, 1);
        add(1, 0, 0, 1, 0,   2,  1, 0, 0, 1);
        add(1, 0, 0, 1, 0,   2,  2, 0, 0, 1);
        add(1, 0, 0, 1, 0,   2,  3, 0, 0, 1);
        add(1, 0, 1, 0, 0,   3,  3, 0, 0, 1);
        add(1, 0, 0, 1, 0,   3,  4, 0, 0, 1);
        add(1, 0, 1, 0, 0,   3,  3, 0, 0, 1);
        add(1, 0, 1, 0, 0,   4,  3, 0, 0, 1);
        add(1, 0, 1, 0, 0,   4,  3, 1, 0, 1);
        add(1, 0, 0, 1, 0,   4,  3, 1, 0, 0);
        add(1, 0, 0, 0, 1,   0,  0, 0, 0, 0);
        add(1, 0, 0, 1, 0,   0,  1, 0, 0, 1);
        add(1, 0, 0, 1, 0,   0,  2, 0, 0, 1);
        add(1, 0, 0, 1, 0,   0,  3, 0, 0, 1);
        add(1, 0, 0, 1, 0,   0,  3, 0, 1, 1);
        add(0, 0, 0, 0, 0,   0,  0, 0, 0, 0);
        add(0, 3, 1, 0, 0,   4,  3, 0, 0, 1);
        add(0, 0, 1, 0, 0,   5,  3, 0, 0, 1);
        add(1, 0, 0, 0, 0,   0,  0, 0, 0, 0);

        for (int i = 0; i < nv; i++) begin
            base = pulse_cnt;
            if (vecs[i].mode != mode_tennis_i) begin
                mode_tennis_i = vecs[i].mode;
                repeat (4) @(negedge clk_i);
            end
            for (int k = 0; k < vecs[i].fill; k++) begin
                press(1'b1, 1'b0, 1'b0);
                press(1'b0, 1'b1, 1'b0);
            end
            if (vecs[i].fill > 0) base = pulse_cnt;
            if (vecs[i].b1 || vecs[i].b2 || vecs[i].bn) begin
                press(vecs[i].b1, vecs[i].b2, vecs[i].bn);
            end else begin
                repeat (4) @(negedge clk_i);
            end
            check_all($sformatf("vec%0d", i), int'(vecs[i].e1), int'(vecs[i].e2),
                      int'(vecs[i].ew1), int'(vecs[i].ew2), vecs[i].epul, base);
        end

        // reset in the middle of a debounce, button still held after release
        base = pulse_cnt;
        p1_btn_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        p1_btn_i = 1'b0;
        repeat (15) @(negedge clk_i);
        check_all("rst_mid", 0, 0, 0, 0, 0, base);

        // mode was reloaded as tennis at reset: four P1 points win at code 3
        base = pulse_cnt;
        repeat (4) press(1'b1, 1'b0, 1'b0);
        check_all("post_rst", 3, 0, 1, 0, 4, base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard bound on run time
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
